// File: rtl/fft_stage_folded.sv
// fft_stage_folded
//   One stage of an N_SAMPLES-point radix-2 DIT FFT. The stage is folded so that
//   N_BFLY butterfly units are reused over P = N_SAMPLES/(2*N_BFLY) passes, one
//   pass per clock. Supports inverse mode (conjugated twiddles) and optional
//   1/2 scaling of every butterfly output.
//
//   Ports
//     clk, reset        : clock, asynchronous active-high reset
//     recv_msg_real/imag: input frame, sample k at [k*BIT_WIDTH +: BIT_WIDTH]
//     recv_inverse      : inverse mode for the frame, latched at accept
//     recv_val/recv_rdy : whole-frame input handshake
//     send_msg_real/imag: result frame (driven directly from the internal bank)
//     send_val/send_rdy : whole-frame output handshake
//     sine_wave_in      : sine table, entry k = sin(2*pi*k/N_SAMPLES)
module fft_stage_folded #(
    parameter int BIT_WIDTH  = 32,
    parameter int DECIMAL_PT = 16,
    parameter int N_SAMPLES  = 8,
    parameter int STAGE_FFT  = 0,
    parameter int N_BFLY     = 2,
    parameter int SCALE      = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_SAMPLES*BIT_WIDTH-1:0] recv_msg_real,
    input  logic [N_SAMPLES*BIT_WIDTH-1:0] recv_msg_imag,
    input  logic                           recv_inverse,
    input  logic                           recv_val,
    output logic                           recv_rdy,
    output logic [N_SAMPLES*BIT_WIDTH-1:0] send_msg_real,
    output logic [N_SAMPLES*BIT_WIDTH-1:0] send_msg_imag,
    output logic                           send_val,
    input  logic                           send_rdy,
    input  logic [N_SAMPLES*BIT_WIDTH-1:0] sine_wave_in
);

    localparam int unsigned P         = N_SAMPLES / (2 * N_BFLY);
    localparam int unsigned PCW       = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned IW        = $clog2(N_SAMPLES);
    localparam int unsigned SPAN      = 1 << STAGE_FFT;
    localparam int unsigned TW_STEP   = N_SAMPLES / (2 * SPAN);
    localparam logic [PCW-1:0] LAST_PASS = PCW'(P - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                       state, state_nxt;
    logic [PCW-1:0]               pass_cnt;
    logic                         inv;
    logic                         accept;

    logic signed [BIT_WIDTH-1:0]  bank_re  [N_SAMPLES];
    logic signed [BIT_WIDTH-1:0]  bank_im  [N_SAMPLES];
    logic signed [BIT_WIDTH-1:0]  sine_arr [N_SAMPLES];

    logic [IW-1:0]                top_idx [N_BFLY];
    logic [IW-1:0]                bot_idx [N_BFLY];
    logic signed [BIT_WIDTH-1:0]  c_re [N_BFLY];
    logic signed [BIT_WIDTH-1:0]  c_im [N_BFLY];
    logic signed [BIT_WIDTH-1:0]  d_re [N_BFLY];
    logic signed [BIT_WIDTH-1:0]  d_im [N_BFLY];

    // Fixed-point multiply: full-width signed product, floor shift, truncate.
    function automatic logic signed [BIT_WIDTH-1:0] fx_mul(
        input logic signed [BIT_WIDTH-1:0] a,
        input logic signed [BIT_WIDTH-1:0] b
    );
        logic signed [2*BIT_WIDTH-1:0] prod;
        prod = {{BIT_WIDTH{a[BIT_WIDTH-1]}}, a} * {{BIT_WIDTH{b[BIT_WIDTH-1]}}, b};
        return prod[DECIMAL_PT +: BIT_WIDTH];
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (recv_val) state_nxt = COMPUTE;
            COMPUTE: if (pass_cnt == LAST_PASS) state_nxt = DONE;
            DONE:    if (send_rdy) state_nxt = recv_val ? COMPUTE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        recv_rdy = (state == IDLE) || ((state == DONE) && send_rdy);
        send_val = (state == DONE);
    end

    assign accept = recv_val && recv_rdy;

    // ---------------- Butterfly datapath ----------------
    always_comb begin
        for (int unsigned k = 0; k < N_SAMPLES; k++) begin
            sine_arr[k] = sine_wave_in[k*BIT_WIDTH +: BIT_WIDTH];
        end
    end

    always_comb begin : bfly_datapath
        int unsigned                 bfly, q, ix;
        logic signed [BIT_WIDTH-1:0] a_re, a_im, b_re, b_im;
        logic signed [BIT_WIDTH-1:0] w_re, w_im, t_re, t_im;
        logic signed [BIT_WIDTH-1:0] s_re, s_im, m_re, m_im;
        bfly = 0; q = 0; ix = 0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0;
        w_re = '0; w_im = '0; t_re = '0; t_im = '0;
        s_re = '0; s_im = '0; m_re = '0; m_im = '0;
        for (int unsigned j = 0; j < N_BFLY; j++) begin
            bfly       = 32'(pass_cnt) * N_BFLY + j;
            q          = bfly % SPAN;
            top_idx[j] = IW'((bfly / SPAN) * 2 * SPAN + q);
            bot_idx[j] = IW'((bfly / SPAN) * 2 * SPAN + q + SPAN);
            a_re = bank_re[top_idx[j]];
            a_im = bank_im[top_idx[j]];
            b_re = bank_re[bot_idx[j]];
            b_im = bank_im[bot_idx[j]];
            ix   = q * TW_STEP;
            // Table index truncated to IW bits gives the mod-N wrap for free.
            w_re = sine_arr[IW'(ix + N_SAMPLES/4)];
            w_im = inv ? sine_arr[IW'(ix)] : -sine_arr[IW'(ix)];
            if (ix == 0) begin
                t_re = b_re;
                t_im = b_im;
            end else begin
                t_re = fx_mul(w_re, b_re) - fx_mul(w_im, b_im);
                t_im = fx_mul(w_re, b_im) + fx_mul(w_im, b_re);
            end
            s_re = a_re + t_re;
            s_im = a_im + t_im;
            m_re = a_re - t_re;
            m_im = a_im - t_im;
            if (SCALE != 0) begin
                c_re[j] = s_re >>> 1;
                c_im[j] = s_im >>> 1;
                d_re[j] = m_re >>> 1;
                d_im[j] = m_im >>> 1;
            end else begin
                c_re[j] = s_re;
                c_im[j] = s_im;
                d_re[j] = m_re;
                d_im[j] = m_im;
            end
        end
    end

    // ---------------- Bank, pass counter, mode ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_cnt <= '0;
            inv      <= 1'b0;
            for (int unsigned k = 0; k < N_SAMPLES; k++) begin
                bank_re[k] <= '0;
                bank_im[k] <= '0;
            end
        end else if (accept) begin
            pass_cnt <= '0;
            inv      <= recv_inverse;
            for (int unsigned k = 0; k < N_SAMPLES; k++) begin
                bank_re[k] <= recv_msg_real[k*BIT_WIDTH +: BIT_WIDTH];
                bank_im[k] <= recv_msg_imag[k*BIT_WIDTH +: BIT_WIDTH];
            end
        end else if (state == COMPUTE) begin
            // Butterfly indices within a pass are disjoint, so in-place writes never collide.
            for (int unsigned j = 0; j < N_BFLY; j++) begin
                bank_re[top_idx[j]] <= c_re[j];
                bank_im[top_idx[j]] <= c_im[j];
                bank_re[bot_idx[j]] <= d_re[j];
                bank_im[bot_idx[j]] <= d_im[j];
            end
            pass_cnt <= (pass_cnt == LAST_PASS) ? '0 : pass_cnt + PCW'(1);
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < N_SAMPLES; k++) begin
            send_msg_real[k*BIT_WIDTH +: BIT_WIDTH] = bank_re[k];
            send_msg_imag[k*BIT_WIDTH +: BIT_WIDTH] = bank_im[k];
        end
    end

endmodule

// File: tb/tb_fft_stage_folded.sv
module tb_fft_stage_folded;

    localparam int BW   = 32;
    localparam int N    = 8;
    localparam int NCFG = 10;

    typedef int frame_t [N];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [N*BW-1:0] in_re, in_im, sine;
    logic            in_inv;
    logic            recv_val [NCFG];
    logic            send_rdy [NCFG];
    logic            recv_rdy [NCFG];
    logic            send_val [NCFG];
    logic [N*BW-1:0] out_re   [NCFG];
    logic [N*BW-1:0] out_im   [NCFG];

    int checks = 0;
    int errors = 0;

    int sine_tab [N] = '{0, 'hB505, 'h10000, 'hB505, 0, -'hB505, -'h10000, -'hB505};

    // Instances 0..8: N_BFLY = 1<<(g/3), STAGE_FFT = g%3. Instance 9: SCALE=1, stage 0.
    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int NB  = (g == 9) ? 2 : (1 << (g / 3));
        localparam int STG = (g == 9) ? 0 : (g % 3);
        localparam int SC  = (g == 9) ? 1 : 0;
        fft_stage_folded #(
            .BIT_WIDTH(BW), .DECIMAL_PT(16), .N_SAMPLES(N),
            .STAGE_FFT(STG), .N_BFLY(NB), .SCALE(SC)
        ) u_dut (
            .clk(clk), .reset(reset),
            .recv_msg_real(in_re), .recv_msg_imag(in_im),
            .recv_inverse(in_inv), .recv_val(recv_val[g]), .recv_rdy(recv_rdy[g]),
            .send_msg_real(out_re[g]), .send_msg_imag(out_im[g]),
            .send_val(send_val[g]), .send_rdy(send_rdy[g]),
            .sine_wave_in(sine)
        );
    end

    function automatic int cfg_stage(input int ci); return (ci == 9) ? 0 : ci % 3; endfunction
    function automatic int cfg_lat(input int ci);
        int nb;
        nb = (ci == 9) ? 2 : (1 << (ci / 3));
        return N / (2 * nb) + 1;
    endfunction

    // Reference: one radix-2 DIT stage computed group by group, straight from the definition.
    function automatic void ref_stage(input frame_t re_i, input frame_t im_i, input int stg,
                                      input bit inv, input bit sc,
                                      output frame_t re_o, output frame_t im_o);
        int span;
        span = 1 << stg;
        re_o = re_i;
        im_o = im_i;
        for (int base = 0; base < N; base += 2 * span) begin
            for (int q = 0; q < span; q++) begin
                int a, b, k, tr, ti, cr, cim, dr, dim;
                longint wr, wi;
                a = base + q;
                b = a + span;
                k = q * (N / (2 * span));
                wr = sine_tab[(k + N/4) % N];
                wi = inv ? sine_tab[k] : -sine_tab[k];
                if (k == 0) begin
                    tr = re_i[b];
                    ti = im_i[b];
                end else begin
                    tr = int'((wr * re_i[b]) >>> 16) - int'((wi * im_i[b]) >>> 16);
                    ti = int'((wr * im_i[b]) >>> 16) + int'((wi * re_i[b]) >>> 16);
                end
                cr = re_i[a] + tr; cim = im_i[a] + ti;
                dr = re_i[a] - tr; dim = im_i[a] - ti;
                if (sc) begin
                    cr = cr >>> 1; cim = cim >>> 1; dr = dr >>> 1; dim = dim >>> 1;
                end
                re_o[a] = cr; im_o[a] = cim;
                re_o[b] = dr; im_o[b] = dim;
            end
        end
    endfunction

    function automatic logic [N*BW-1:0] pack(input frame_t f);
        logic [N*BW-1:0] v;
        for (int k = 0; k < N; k++) v[k*BW +: BW] = f[k];
        return v;
    endfunction

    function automatic void rand_frame(output frame_t re, output frame_t im);
        for (int k = 0; k < N; k++) begin
            re[k] = $urandom;
            im[k] = $urandom;
        end
    endfunction

    task automatic scramble_inputs();
        for (int k = 0; k < N; k++) begin
            in_re[k*BW +: BW] = $urandom;
            in_im[k*BW +: BW] = $urandom;
        end
        in_inv = 1'($urandom_range(0, 1));
    endtask

    task automatic load_inputs(input frame_t re, input frame_t im, input bit inv);
        in_re  = pack(re);
        in_im  = pack(im);
        in_inv = inv;
    endtask

    // Present a frame at a negedge, hold until accepted (bounded), then scramble inputs.
    task automatic drive_frame(input int ci, input frame_t re, input frame_t im, input bit inv);
        int n;
        n = 0;
        @(negedge clk);
        load_inputs(re, im, inv);
        while (recv_rdy[ci] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        recv_val[ci] = 1'b1;
        @(posedge clk);
        #1;
        recv_val[ci] = 1'b0;
        scramble_inputs();
    endtask

    // Cycles from the handshake cycle until send_val is seen; -1 if it never comes.
    task automatic wait_result(input int ci, output int lat);
        lat = -1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (send_val[ci] === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int ci = 0; ci < NCFG; ci++) begin
            checks++;
            if (send_val[ci] !== 1'b0 || out_re[ci] !== '0 || out_im[ci] !== '0) begin
                errors++;
                $display("FAIL reset_state ci=%0d send_val=%b re=%h im=%h expected 0", ci,
                         send_val[ci], out_re[ci], out_im[ci]);
            end
        end
        reset = 1'b0;
        #1;
        for (int ci = 0; ci < NCFG; ci++) begin
            checks++;
            if (recv_rdy[ci] !== 1'b1) begin
                errors++;
                $display("FAIL reset_rdy ci=%0d got=%b expected=1", ci, recv_rdy[ci]);
            end
        end
    endtask

    task automatic test_basic();
        frame_t re, im, er, ei;
        int lat;
        for (int k = 0; k < N; k++) begin re[k] = 0; im[k] = 0; er[k] = 0; ei[k] = 0; end
        re[0] = 'h10000; re[1] = 'h20000;
        er[0] = 'h30000; er[1] = 32'hFFFF0000;
        drive_frame(3, re, im, 1'b0);
        wait_result(3, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL basic_latency got=%0d expected=3", lat); end
        checks++;
        if (out_re[3] !== pack(er)) begin
            errors++; $display("FAIL basic_real got=%h expected=%h", out_re[3], pack(er));
        end
        checks++;
        if (out_im[3] !== pack(ei)) begin
            errors++; $display("FAIL basic_imag got=%h expected=%h", out_im[3], pack(ei));
        end
    endtask

    task automatic test_twiddle();
        frame_t re, im, er, ei;
        int lat;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < N; k++) begin re[k] = 0; im[k] = 0; er[k] = 0; ei[k] = 0; end
            re[6] = 'h10000;
            ei[2] = (m == 0) ? 32'hFFFF0000 : 'h10000;
            ei[6] = (m == 0) ? 'h10000 : 32'hFFFF0000;
            drive_frame(5, re, im, 1'(m));
            wait_result(5, lat);
            checks++;
            if (lat !== 3) begin errors++; $display("FAIL twiddle_latency inv=%0d got=%0d expected=3", m, lat); end
            checks++;
            if (out_re[5] !== pack(er)) begin
                errors++; $display("FAIL twiddle_real inv=%0d got=%h expected=%h", m, out_re[5], pack(er));
            end
            checks++;
            if (out_im[5] !== pack(ei)) begin
                errors++; $display("FAIL twiddle_imag inv=%0d got=%h expected=%h", m, out_im[5], pack(ei));
            end
        end
    endtask

    task automatic test_backpressure();
        frame_t r1, i1, r2, i2, e1r, e1i, e2r, e2i;
        int lat;
        rand_frame(r1, i1);
        rand_frame(r2, i2);
        ref_stage(r1, i1, 0, 1'b0, 1'b0, e1r, e1i);
        ref_stage(r2, i2, 0, 1'b1, 1'b0, e2r, e2i);
        send_rdy[3] = 1'b0;
        drive_frame(3, r1, i1, 1'b0);
        wait_result(3, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL bp_latency got=%0d expected=3", lat); end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (send_val[3] !== 1'b1 || recv_rdy[3] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d send_val=%b recv_rdy=%b expected 1/0", c, send_val[3], recv_rdy[3]);
            end
            checks++;
            if (out_re[3] !== pack(e1r) || out_im[3] !== pack(e1i)) begin
                errors++;
                $display("FAIL bp_stable cyc=%0d re=%h im=%h expected re=%h im=%h", c,
                         out_re[3], out_im[3], pack(e1r), pack(e1i));
            end
            @(negedge clk);
        end
        send_rdy[3] = 1'b1;
        load_inputs(r2, i2, 1'b1);
        recv_val[3] = 1'b1;
        #1;
        checks++;
        if (recv_rdy[3] !== 1'b1) begin errors++; $display("FAIL bp_release_rdy got=%b expected=1", recv_rdy[3]); end
        @(posedge clk);
        #1;
        recv_val[3] = 1'b0;
        scramble_inputs();
        wait_result(3, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL b2b_latency got=%0d expected=3", lat); end
        checks++;
        if (out_re[3] !== pack(e2r) || out_im[3] !== pack(e2i)) begin
            errors++;
            $display("FAIL b2b_result re=%h im=%h expected re=%h im=%h", out_re[3], out_im[3], pack(e2r), pack(e2i));
        end
    endtask

    task automatic test_reset_mid();
        frame_t re, im, er, ei;
        int lat;
        rand_frame(re, im);
        drive_frame(3, re, im, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (send_val[3] !== 1'b0 || out_re[3] !== '0 || out_im[3] !== '0) begin
            errors++;
            $display("FAIL reset_mid_clear send_val=%b re=%h im=%h expected 0", send_val[3], out_re[3], out_im[3]);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (recv_rdy[3] !== 1'b1) begin errors++; $display("FAIL reset_mid_rdy got=%b expected=1", recv_rdy[3]); end
        rand_frame(re, im);
        ref_stage(re, im, 0, 1'b0, 1'b0, er, ei);
        drive_frame(3, re, im, 1'b0);
        wait_result(3, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL reset_mid_latency got=%0d expected=3", lat); end
        checks++;
        if (out_re[3] !== pack(er) || out_im[3] !== pack(ei)) begin
            errors++;
            $display("FAIL reset_mid_result re=%h im=%h expected re=%h im=%h", out_re[3], out_im[3], pack(er), pack(ei));
        end
    endtask

    task automatic test_scale();
        frame_t re, im, er, ei;
        int lat;
        bit inv;
        for (int k = 0; k < N; k++) begin re[k] = 0; im[k] = 0; er[k] = 0; ei[k] = 0; end
        re[0] = 'h7FFF0000; re[1] = 'h7FFF0000;
        er[0] = 32'hFFFF0000;
        drive_frame(9, re, im, 1'b0);
        wait_result(9, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL scale_latency got=%0d expected=3", lat); end
        checks++;
        if (out_re[9] !== pack(er) || out_im[9] !== pack(ei)) begin
            errors++;
            $display("FAIL scale_wrap re=%h im=%h expected re=%h im=%h", out_re[9], out_im[9], pack(er), pack(ei));
        end
        for (int t = 0; t < 3; t++) begin
            rand_frame(re, im);
            inv = 1'($urandom_range(0, 1));
            ref_stage(re, im, 0, inv, 1'b1, er, ei);
            drive_frame(9, re, im, inv);
            wait_result(9, lat);
            checks++;
            if (out_re[9] !== pack(er) || out_im[9] !== pack(ei)) begin
                errors++;
                $display("FAIL scale_random t=%0d re=%h im=%h expected re=%h im=%h", t, out_re[9], out_im[9], pack(er), pack(ei));
            end
        end
    endtask

    task automatic test_sweep();
        frame_t re, im, er, ei;
        int lat;
        bit inv;
        for (int ci = 0; ci < 9; ci++) begin
            for (int t = 0; t < 4; t++) begin
                rand_frame(re, im);
                inv = 1'($urandom_range(0, 1));
                ref_stage(re, im, cfg_stage(ci), inv, 1'b0, er, ei);
                drive_frame(ci, re, im, inv);
                wait_result(ci, lat);
                checks++;
                if (lat !== cfg_lat(ci)) begin
                    errors++; $display("FAIL sweep_latency ci=%0d got=%0d expected=%0d", ci, lat, cfg_lat(ci));
                end
                checks++;
                if (out_re[ci] !== pack(er) || out_im[ci] !== pack(ei)) begin
                    errors++;
                    $display("FAIL sweep_result ci=%0d t=%0d inv=%0d re=%h im=%h expected re=%h im=%h", ci, t, inv,
                             out_re[ci], out_im[ci], pack(er), pack(ei));
                end
            end
        end
    endtask

    task automatic test_busy_ignore();
        frame_t r1, i1, r2, i2, er, ei;
        int lat;
        rand_frame(r1, i1);
        rand_frame(r2, i2);
        ref_stage(r1, i1, 0, 1'b0, 1'b0, er, ei);
        drive_frame(0, r1, i1, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            load_inputs(r2, i2, 1'b1);
            recv_val[0] = 1'b1;
            #1;
            checks++;
            if (recv_rdy[0] !== 1'b0) begin errors++; $display("FAIL busy_rdy cyc=%0d got=%b expected=0", c, recv_rdy[0]); end
        end
        @(posedge clk);
        #1;
        recv_val[0] = 1'b0;
        scramble_inputs();
        wait_result(0, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL busy_latency got=%0d expected=3", lat); end
        checks++;
        if (out_re[0] !== pack(er) || out_im[0] !== pack(ei)) begin
            errors++;
            $display("FAIL busy_result re=%h im=%h expected re=%h im=%h", out_re[0], out_im[0], pack(er), pack(ei));
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int ci = 0; ci < NCFG; ci++) begin
            recv_val[ci] = 1'b0;
            send_rdy[ci] = 1'b1;
        end
        for (int k = 0; k < N; k++) sine[k*BW +: BW] = sine_tab[k];
        scramble_inputs();
        test_reset();
        test_basic();
        test_twiddle();
        test_backpressure();
        test_reset_mid();
        test_scale();
        test_sweep();
        test_busy_ignore();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
